// File: rtl/axi_rsp_pkg.sv
// Shared AXI B-channel constants and helpers.
// Used by the write-response tracker and its FIFO.
package axi_rsp_pkg;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;

   function automatic logic is_err_resp(input logic [1:0] bresp);
      return bresp[1];
   endfunction

endpackage

// File: rtl/axi_rsp_fifo.sv
// Generic synchronous FIFO; head entry is presented on rdata.
// DEPTH must be a power of two so pointers wrap naturally.
module axi_rsp_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             wr;
   logic             rd;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr    = push & ~full;
   assign rd    = pop & ~empty;
   assign rdata = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '{default: '0};
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) begin
            mem[wp] <= wdata;
            wp      <= wp + AW'(1);
         end
         if (rd) begin
            rp <= rp + AW'(1);
         end
         count <= count + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/axi_wr_rsp_tracker.sv
// AXI B-channel stage: buffers responses, tracks in-flight writes,
// throttles AW issue and flags response-protocol anomalies.
module axi_wr_rsp_tracker
   import axi_rsp_pkg::*;
#(
   parameter int ID_WIDTH        = 12,
   parameter int USER_WIDTH      = 1,
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_WIDTH       = 16,
   localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  aw_fire,
   output logic                  aw_allow,
   input  logic [ID_WIDTH-1:0]   dn_bid,
   input  logic [1:0]            dn_bresp,
   input  logic [USER_WIDTH-1:0] dn_buser,
   input  logic                  dn_bvalid,
   output logic                  dn_bready,
   output logic [ID_WIDTH-1:0]   up_bid,
   output logic [1:0]            up_bresp,
   output logic [USER_WIDTH-1:0] up_buser,
   output logic                  up_bvalid,
   input  logic                  up_bready,
   output logic [OW-1:0]         outstanding,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic                  orphan_err,
   output logic                  ovf_err,
   input  logic                  err_clr
);

   localparam int W   = ID_WIDTH + 2 + USER_WIDTH;
   localparam int FCW = $clog2(DEPTH + 1);
   // orphan beats can drain outstanding while pending stays ahead
   localparam int PW  = $clog2(MAX_OUTSTANDING + DEPTH + 1);

   logic           push;
   logic           pop;
   logic           aw_ok;
   logic           full;
   logic           empty;
   logic [FCW-1:0] fcnt;
   logic [FCW-1:0] fcnt_nxt;
   logic [W-1:0]   head;
   logic [PW-1:0]  pend_q;
   logic [PW-1:0]  pend_nxt;
   logic [OW-1:0]  out_nxt;
   logic [CNT_WIDTH-1:0] err_nxt;
   logic           orph_nxt;
   logic           ovf_nxt;

   assign push      = dn_bvalid & dn_bready & ~full;
   assign up_bvalid = ~empty;
   assign pop       = up_bvalid & up_bready;
   assign aw_ok     = aw_fire & aw_allow;
   assign {up_bid, up_bresp, up_buser} = head;

   axi_rsp_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({dn_bid, dn_bresp, dn_buser}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fcnt)
   );

   always_comb begin
      fcnt_nxt = fcnt + FCW'(push) - FCW'(pop);
      out_nxt  = outstanding;
      pend_nxt = pend_q;
      err_nxt  = err_cnt;
      orph_nxt = orphan_err;
      ovf_nxt  = ovf_err;
      unique case (1'b1)
         aw_ok & ~pop:
            out_nxt = outstanding + OW'(1);
         ~aw_ok & pop & (outstanding != '0):
            out_nxt = outstanding - OW'(1);
         default: ;
      endcase
      unique case (1'b1)
         aw_ok & ~push & (pend_q != '1):
            pend_nxt = pend_q + PW'(1);
         ~aw_ok & push & (pend_q != '0):
            pend_nxt = pend_q - PW'(1);
         default: ;
      endcase
      if (push & is_err_resp(dn_bresp) & (err_cnt != '1))
         err_nxt = err_cnt + CNT_WIDTH'(1);
      if (push & (pend_q == '0) & ~aw_ok)
         orph_nxt = 1'b1;
      if (aw_fire & ~aw_allow)
         ovf_nxt = 1'b1;
      if (err_clr) begin
         err_nxt  = '0;
         orph_nxt = 1'b0;
         ovf_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_bready   <= 1'b0;
         aw_allow    <= 1'b0;
         outstanding <= '0;
         pend_q      <= '0;
         err_cnt     <= '0;
         orphan_err  <= 1'b0;
         ovf_err     <= 1'b0;
      end else begin
         dn_bready   <= (fcnt_nxt != FCW'(DEPTH));
         aw_allow    <= (out_nxt < OW'(MAX_OUTSTANDING));
         outstanding <= out_nxt;
         pend_q      <= pend_nxt;
         err_cnt     <= err_nxt;
         orphan_err  <= orph_nxt;
         ovf_err     <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_axi_wr_rsp_tracker.sv
// Bench for axi_wr_rsp_tracker: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_axi_wr_rsp_tracker;

   localparam int IDW  = 12;
   localparam int UW   = 1;
   localparam int DEPTH = 4;
   localparam int MAXO = 16;
   localparam int CW   = 16;
   localparam int OW   = $clog2(MAXO + 1);
   localparam int BW   = IDW + 2 + UW;

   logic           clk;
   logic           rst_n;
   logic           aw_fire;
   logic           aw_allow;
   logic [IDW-1:0] dn_bid;
   logic [1:0]     dn_bresp;
   logic [UW-1:0]  dn_buser;
   logic           dn_bvalid;
   logic           dn_bready;
   logic [IDW-1:0] up_bid;
   logic [1:0]     up_bresp;
   logic [UW-1:0]  up_buser;
   logic           up_bvalid;
   logic           up_bready;
   logic [OW-1:0]  outstanding;
   logic [CW-1:0]  err_cnt;
   logic           orphan_err;
   logic           ovf_err;
   logic           err_clr;

   int n_cmp;
   int n_bad;

   logic [BW-1:0] mq[$];
   int m_out, m_pend, m_err;
   bit m_orph, m_ovf;

   axi_wr_rsp_tracker #(
      .ID_WIDTH(IDW), .USER_WIDTH(UW), .DEPTH(DEPTH),
      .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_fire(aw_fire), .aw_allow(aw_allow),
      .dn_bid(dn_bid), .dn_bresp(dn_bresp), .dn_buser(dn_buser),
      .dn_bvalid(dn_bvalid), .dn_bready(dn_bready),
      .up_bid(up_bid), .up_bresp(up_bresp), .up_buser(up_buser),
      .up_bvalid(up_bvalid), .up_bready(up_bready),
      .outstanding(outstanding), .err_cnt(err_cnt),
      .orphan_err(orphan_err), .ovf_err(ovf_err), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_clear();
      mq.delete();
      m_out = 0; m_pend = 0; m_err = 0;
      m_orph = 0; m_ovf = 0;
   endfunction

   // Spec rules applied to the inputs present just before a rising edge.
   function automatic void model_step();
      bit aw_ok, push, pop;
      aw_ok = aw_fire && (m_out < MAXO);
      push  = dn_bvalid && (mq.size() < DEPTH);
      pop   = up_bready && (mq.size() > 0);
      if (aw_fire && !aw_ok) m_ovf = 1;
      if (push && m_pend == 0 && !aw_ok) m_orph = 1;
      if (push && dn_bresp[1] && m_err < 65535) m_err++;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({dn_bid, dn_bresp, dn_buser});
      m_pend = m_pend + (aw_ok ? 1 : 0) - (push ? 1 : 0);
      if (m_pend < 0) m_pend = 0;
      m_out = m_out + (aw_ok ? 1 : 0) - (pop ? 1 : 0);
      if (m_out < 0) m_out = 0;
      if (err_clr) begin
         m_err = 0; m_orph = 0; m_ovf = 0;
      end
   endfunction

   task automatic idle_inputs();
      aw_fire = 0; dn_bvalid = 0; dn_bid = '0; dn_bresp = '0;
      dn_buser = '0; up_bready = 0; err_clr = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      model_clear();
      #1;
      n_cmp++;
      if (up_bvalid !== 1'b0 || dn_bready !== 1'b0 || aw_allow !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hs: got v=%b r=%b a=%b want 0 0 0",
                  up_bvalid, dn_bready, aw_allow);
      end
      n_cmp++;
      if (outstanding !== '0 || err_cnt !== '0 || orphan_err !== 1'b0 ||
          ovf_err !== 1'b0 || up_bid !== '0 || up_bresp !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got out=%0d err=%0d orph=%b ovf=%b id=%0d want zeros",
                  outstanding, err_cnt, orphan_err, ovf_err, up_bid);
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dn_bready !== 1'b1 || aw_allow !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: got r=%b a=%b want 1 1", dn_bready, aw_allow);
      end
   endtask

   task automatic test_basic();
      aw_fire = 1;
      repeat (3) tick();
      aw_fire = 0;
      n_cmp++;
      if (outstanding !== OW'(3)) begin
         n_bad++;
         $display("FAIL basic_out3: got %0d want 3", outstanding);
      end
      up_bready = 1;
      for (int i = 1; i <= 3; i++) begin
         dn_bvalid = 1; dn_bid = IDW'(i); dn_bresp = 2'b00;
         tick();
         n_cmp++;
         if (up_bvalid !== 1'b1 || up_bid !== IDW'(i)) begin
            n_bad++;
            $display("FAIL basic_beat%0d: got v=%b id=%0d want 1 %0d",
                     i, up_bvalid, up_bid, i);
         end
      end
      dn_bvalid = 0;
      tick();
      n_cmp++;
      if (up_bvalid !== 1'b0 || outstanding !== '0 || orphan_err !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_end: got v=%b out=%0d orph=%b want 0 0 0",
                  up_bvalid, outstanding, orphan_err);
      end
      up_bready = 0;
   endtask

   task automatic test_backpressure();
      int n_push, got;
      bit p;
      up_bready = 0;
      aw_fire = 1;
      repeat (6) tick();
      aw_fire = 0;
      n_push = 0;
      repeat (8) begin
         dn_bvalid = 1; dn_bid = IDW'(10 + n_push); dn_bresp = 2'b00;
         p = dn_bready;
         tick();
         if (p) n_push++;
      end
      n_cmp++;
      if (n_push !== 4 || dn_bready !== 1'b0 || up_bid !== IDW'(10)) begin
         n_bad++;
         $display("FAIL bp_full: got pushes=%0d r=%b head=%0d want 4 0 10",
                  n_push, dn_bready, up_bid);
      end
      up_bready = 1;
      got = 0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         if (n_push < 6) begin
            dn_bvalid = 1; dn_bid = IDW'(10 + n_push);
         end else begin
            dn_bvalid = 0;
         end
         if (up_bvalid) begin
            n_cmp++;
            if (up_bid !== IDW'(10 + got)) begin
               n_bad++;
               $display("FAIL bp_order%0d: got id=%0d want %0d", got, up_bid, 10 + got);
            end
            got++;
         end
         p = dn_bvalid && dn_bready;
         tick();
         if (p) n_push++;
      end
      dn_bvalid = 0;
      tick();
      n_cmp++;
      if (got !== 6 || outstanding !== '0 || up_bvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_drain: got beats=%0d out=%0d v=%b want 6 0 0",
                  got, outstanding, up_bvalid);
      end
      up_bready = 0;
   endtask

   task automatic test_max_outstanding();
      do_reset();
      aw_fire = 1;
      repeat (MAXO) tick();
      n_cmp++;
      if (outstanding !== OW'(MAXO) || aw_allow !== 1'b0 || ovf_err !== 1'b0) begin
         n_bad++;
         $display("FAIL max_hit: got out=%0d a=%b ovf=%b want 16 0 0",
                  outstanding, aw_allow, ovf_err);
      end
      tick();
      aw_fire = 0;
      n_cmp++;
      if (ovf_err !== 1'b1 || outstanding !== OW'(MAXO)) begin
         n_bad++;
         $display("FAIL max_ovf: got ovf=%b out=%0d want 1 16", ovf_err, outstanding);
      end
      dn_bvalid = 1; dn_bid = IDW'(5);
      tick();
      dn_bvalid = 0; up_bready = 1;
      tick();
      up_bready = 0;
      n_cmp++;
      if (outstanding !== OW'(MAXO - 1) || aw_allow !== 1'b1 || orphan_err !== 1'b0) begin
         n_bad++;
         $display("FAIL max_release: got out=%0d a=%b orph=%b want 15 1 0",
                  outstanding, aw_allow, orphan_err);
      end
   endtask

   task automatic test_orphan();
      do_reset();
      dn_bvalid = 1; dn_bid = IDW'(7); dn_bresp = 2'b00;
      tick();
      dn_bvalid = 0;
      n_cmp++;
      if (orphan_err !== 1'b1 || up_bvalid !== 1'b1 || up_bid !== IDW'(7) ||
          outstanding !== '0) begin
         n_bad++;
         $display("FAIL orphan: got orph=%b v=%b id=%0d out=%0d want 1 1 7 0",
                  orphan_err, up_bvalid, up_bid, outstanding);
      end
      up_bready = 1;
      tick();
      up_bready = 0;
      n_cmp++;
      if (up_bvalid !== 1'b0 || outstanding !== '0) begin
         n_bad++;
         $display("FAIL orphan_drain: got v=%b out=%0d want 0 0", up_bvalid, outstanding);
      end
   endtask

   task automatic test_err_count();
      logic [1:0] rs [4];
      rs = '{2'b10, 2'b11, 2'b00, 2'b01};
      do_reset();
      up_bready = 1;
      for (int i = 0; i < 4; i++) begin
         dn_bvalid = 1; dn_bid = IDW'(i); dn_bresp = rs[i];
         tick();
      end
      dn_bvalid = 0;
      tick();
      n_cmp++;
      if (err_cnt !== CW'(2) || orphan_err !== 1'b1) begin
         n_bad++;
         $display("FAIL err_cnt: got %0d orph=%b want 2 1", err_cnt, orphan_err);
      end
      dn_bvalid = 1; dn_bresp = 2'b10; err_clr = 1;
      tick();
      dn_bvalid = 0; err_clr = 0;
      n_cmp++;
      if (err_cnt !== '0 || orphan_err !== 1'b0 || ovf_err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clr: got err=%0d orph=%b ovf=%b want 0 0 0",
                  err_cnt, orphan_err, ovf_err);
      end
      tick();
      up_bready = 0;
   endtask

   task automatic test_mid_reset();
      int stale;
      do_reset();
      aw_fire = 1;
      repeat (5) tick();
      aw_fire = 0;
      for (int i = 0; i < 2; i++) begin
         dn_bvalid = 1; dn_bid = IDW'(8'h21 + i);
         tick();
      end
      dn_bvalid = 0;
      n_cmp++;
      if (outstanding !== OW'(5) || up_bvalid !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_pre: got out=%0d v=%b want 5 1", outstanding, up_bvalid);
      end
      rst_n = 0;
      model_clear();
      #1;
      n_cmp++;
      if (up_bvalid !== 1'b0 || outstanding !== '0 || dn_bready !== 1'b0 ||
          aw_allow !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_async: got v=%b out=%0d r=%b a=%b want 0 0 0 0",
                  up_bvalid, outstanding, dn_bready, aw_allow);
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (dn_bready !== 1'b1 || aw_allow !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_release: got r=%b a=%b want 1 1", dn_bready, aw_allow);
      end
      up_bready = 1;
      stale = 0;
      repeat (5) begin
         if (up_bvalid) stale++;
         tick();
      end
      up_bready = 0;
      n_cmp++;
      if (stale !== 0) begin
         n_bad++;
         $display("FAIL midrst_stale: got %0d stale beats want 0", stale);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         n_cmp++;
         if (up_bvalid !== (mq.size() > 0)) begin
            n_bad++;
            $display("FAIL rnd_valid c%0d: got %b want %b", c, up_bvalid, mq.size() > 0);
         end
         if (mq.size() > 0) begin
            n_cmp++;
            if ({up_bid, up_bresp, up_buser} !== mq[0]) begin
               n_bad++;
               $display("FAIL rnd_data c%0d: got %h want %h",
                        c, {up_bid, up_bresp, up_buser}, mq[0]);
            end
         end
         n_cmp++;
         if (dn_bready !== (mq.size() < DEPTH) || aw_allow !== (m_out < MAXO)) begin
            n_bad++;
            $display("FAIL rnd_ready c%0d: got r=%b a=%b want %b %b",
                     c, dn_bready, aw_allow, mq.size() < DEPTH, m_out < MAXO);
         end
         n_cmp++;
         if (outstanding !== OW'(m_out) || err_cnt !== CW'(m_err)) begin
            n_bad++;
            $display("FAIL rnd_cnt c%0d: got out=%0d err=%0d want %0d %0d",
                     c, outstanding, err_cnt, m_out, m_err);
         end
         n_cmp++;
         if (orphan_err !== m_orph || ovf_err !== m_ovf) begin
            n_bad++;
            $display("FAIL rnd_flags c%0d: got orph=%b ovf=%b want %b %b",
                     c, orphan_err, ovf_err, m_orph, m_ovf);
         end
         aw_fire   = ($urandom_range(99) < 45);
         dn_bvalid = ($urandom_range(99) < 50);
         dn_bid    = IDW'($urandom);
         dn_bresp  = 2'($urandom);
         dn_buser  = UW'($urandom);
         up_bready = ($urandom_range(99) < 55);
         err_clr   = ($urandom_range(99) < 3);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1;
      idle_inputs();
      model_clear();
      test_reset();
      test_basic();
      test_backpressure();
      test_max_outstanding();
      test_orphan();
      test_err_count();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/axi_wr_rsp_tracker.md
Name: axi_wr_rsp_tracker

Overview:
Parametrised AXI write-response (B) channel stage placed between a downstream AXI slave and an upstream master port.
- Buffers B beats in a DEPTH-entry FIFO.
- Tracks outstanding write transactions from AW handshakes and throttles AW issue at MAX_OUTSTANDING.
- Counts error responses and flags protocol anomalies: orphan responses and AW overflow.
- Used on each write port of the CNN memory subsystem in place of a bare B-channel connection.

Parameters:
ID_WIDTH, 12, width of bid
USER_WIDTH, 1, width of buser
DEPTH, 4, response FIFO entries; power of two, ≥2
MAX_OUTSTANDING, 16, maximum in-flight writes; ≥1
CNT_WIDTH, 16, width of the error counter

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
aw_fire  input  1  pulse: AW handshake completed this cycle
aw_allow  output  1  high when another AW may be issued
dn_bid  input  ID_WIDTH  downstream response ID
dn_bresp  input  2  downstream response code
dn_buser  input  USER_WIDTH  downstream user bits
dn_bvalid  input  1  downstream valid
dn_bready  output  1  downstream ready
up_bid  output  ID_WIDTH  upstream response ID
up_bresp  output  2  upstream response code
up_buser  output  USER_WIDTH  upstream user bits
up_bvalid  output  1  upstream valid
up_bready  input  1  upstream ready
outstanding  output  $clog2(MAX_OUTSTANDING+1)  writes issued but not yet acknowledged upstream
err_cnt  output  CNT_WIDTH  saturating count of SLVERR/DECERR responses
orphan_err  output  1  sticky: downstream B arrived with no pending write
ovf_err  output  1  sticky: aw_fire seen while aw_allow low
err_clr  input  1  synchronous clear of err_cnt, orphan_err, ovf_err

Behaviour:
- Reset (rst_n low, async): FIFO empty, up_bvalid=0, up_bid/up_bresp/up_buser=0, dn_bready=0 while rst_n low, outstanding=0, pending_dn=0, err_cnt=0, orphan_err=0, ovf_err=0, aw_allow=0 while rst_n low. First cycle after release: dn_bready=1, aw_allow=1.
- Reset mid-operation: all in-flight beats are discarded; no up_bvalid after release until a new dn push.
- FIFO:
  - Push on dn_bvalid&dn_bready. dn_bready = !full, registered; full inhibits push even if a pop occurs the same cycle.
  - Pop on up_bvalid&up_bready. Outputs are driven from the FIFO head.
  - Latency: a beat pushed in cycle N is visible on up_* in cycle N+1.
  - up_* held stable while up_bvalid & !up_bready (AXI rule).
  - Simultaneous push/pop when not full and not empty: count unchanged, full throughput of 1 beat/cycle.
  - Read/write pointers wrap modulo DEPTH.
- Counters:
  - outstanding: +1 on accepted aw_fire, −1 on upstream B handshake; both in one cycle → unchanged. Saturates at 0, never underflows.
  - pending_dn (internal): +1 on accepted aw_fire, −1 on dn push.
  - aw_allow = (outstanding < MAX_OUTSTANDING), registered from the next-state value.
  - aw_fire while aw_allow=0: ignored for counting, ovf_err set.
- Orphan: dn push with pending_dn==0 and no accepted aw_fire the same cycle → orphan_err set. The beat is still buffered and forwarded, and pending_dn stays 0.
- Error count: dn push with dn_bresp[1]==1 → err_cnt+1, saturating at all-ones.
- err_clr: clear wins over a same-cycle increment or set, giving err_cnt=0 and flags=0 in the next cycle.
- All outputs are registered; there is no combinational path from dn_* to up_* or from up_bready to dn_bready.

Decomposition:
- Package axi_rsp_pkg holds:
  - BRESP_OKAY=2'b00, BRESP_EXOKAY=2'b01, BRESP_SLVERR=2'b10, BRESP_DECERR=2'b11
  - function is_err_resp(bresp)
- One sub-module, axi_rsp_fifo: generic synchronous FIFO parametrised by width and depth, exporting full/empty/count. The tracker instantiates it with width ID_WIDTH+2+USER_WIDTH.

Test Plan:
- 3 aw_fire pulses, then 3 OKAY beats (IDs 1,2,3) with up_bready=1 → up_* carry IDs 1,2,3 in order, each 1 cycle after push; outstanding ends at 0.
- up_bready=0, DEPTH=4, 6 writes issued, 6 dn beats offered → dn_bready drops after 4th push; raising up_bready drains 4 then accepts remaining 2, order preserved.
- MAX_OUTSTANDING=16, 16 aw_fire → aw_allow=0; 17th aw_fire → ovf_err=1, outstanding stays 16; one upstream B handshake → outstanding=15, aw_allow=1.
- dn beat with no prior aw_fire → orphan_err=1, beat still appears on up_*, outstanding remains 0.
- Beats with bresp 10, 11, 00, 01 → err_cnt=2. err_clr asserted in the same cycle as another SLVERR push → err_cnt=0 next cycle.
- rst_n pulsed low with 2 beats buffered and outstanding=5 → immediately up_bvalid=0 and outstanding=0; after release dn_bready=1, aw_allow=1, no stale beats emitted.
